// File: rtl/mips_mem_responder.sv
// Word-addressed memory responder for a MIPS-32 pipeline initiator: one outstanding request,
// a programmable wait-state delay before the array access, and range-checked addresses.
module mips_mem_responder #(
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [15:0]       txn_count
);

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        wait_cnt_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic              rsp_valid_reg;
  logic              rsp_err_reg;
  logic              rsp_load_reg;
  logic [15:0]       txn_count_reg;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       mem_rdata_reg;
  logic [IDX_W-1:0]  mem_idx;
  logic              in_range;
  logic              mem_we;
  logic              mem_re;

  // The extra top bit lets DEPTH equal 2**ADDR_W without the compare overflowing.
  assign in_range = {1'b0, addr_reg} < DEPTH_LIM;
  assign mem_idx  = addr_reg[IDX_W-1:0];
  assign mem_we   = (state_reg == S_ACCESS) && we_reg && in_range && !rst;
  assign mem_re   = (state_reg == S_ACCESS) && !we_reg && in_range;

  always_ff @(posedge clk1) begin
    if (mem_we) mem[mem_idx] <= wdata_reg;
    if (mem_re) mem_rdata_reg <= mem[mem_idx];
  end

  // State register
  always_ff @(posedge clk1) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE:   if (req_valid) state_next = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:   if (wait_cnt_reg <= 4'd1) state_next = S_ACCESS;
      S_ACCESS: state_next = S_RESP;
      S_RESP:   if (rsp_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Request latch, wait counter and response registers
  always_ff @(posedge clk1) begin
    if (rst) begin
      wait_cnt_reg  <= 4'd0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_load_reg  <= 1'b0;
      txn_count_reg <= 16'd0;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          if (req_valid) begin
            we_reg       <= req_we;
            addr_reg     <= req_addr;
            wdata_reg    <= req_wdata;
            wait_cnt_reg <= WAIT_LOAD;
          end
        end
        S_WAIT: wait_cnt_reg <= wait_cnt_reg - 4'd1;
        S_ACCESS: begin
          rsp_valid_reg <= 1'b1;
          rsp_err_reg   <= !in_range;
          rsp_load_reg  <= in_range && !we_reg;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            txn_count_reg <= txn_count_reg + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b1;
    if (state_reg == S_IDLE) begin
      req_ready = !rst;
      busy      = 1'b0;
    end
  end

  // Stores and errors report zero data; the array output is only exposed for in-range loads.
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_load_reg ? mem_rdata_reg : 32'd0;
  assign txn_count = txn_count_reg;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Bench for mips_mem_responder: a WAIT_CYCLES=2 instance for function and a WAIT_CYCLES=0
// instance for throughput, both checked against an array/counter reference model.
module tb_mips_mem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT2  = 2 + 2;   // cycle index of first rsp_valid after acceptance
  localparam int LAT0  = 0 + 2;
  localparam int PER0  = 0 + 3;   // back-to-back period for the zero-wait build

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic        rst2, req_valid2, req_ready2, req_we2, rsp_valid2, rsp_ready2, rsp_err2, busy2;
  logic [11:0] req_addr2;
  logic [31:0] req_wdata2, rsp_rdata2;
  logic [15:0] txn_count2;

  logic        rst0, req_valid0, req_ready0, req_we0, rsp_valid0, rsp_ready0, rsp_err0, busy0;
  logic [11:0] req_addr0;
  logic [31:0] req_wdata0, rsp_rdata0;
  logic [15:0] txn_count0;

  mips_mem_responder #(.ADDR_W(12), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut2 (
    .clk1(clk1), .rst(rst2), .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2),
    .req_addr(req_addr2), .req_wdata(req_wdata2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
    .rsp_rdata(rsp_rdata2), .rsp_err(rsp_err2), .busy(busy2), .txn_count(txn_count2)
  );

  mips_mem_responder #(.ADDR_W(12), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk1(clk1), .rst(rst0), .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .busy(busy0), .txn_count(txn_count0)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: contents of every in-range word written so far, and completed responses.
  logic [31:0] model_mem [int];
  int          written [$];
  int          model_cnt2 = 0;

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  function automatic logic [31:0] exp_rdata(input logic we, input logic [11:0] a);
    if (we || int'(a) >= DEPTH) return 32'd0;
    return model_mem[int'(a)];
  endfunction

  function automatic void model_apply(input logic we, input logic [11:0] a, input logic [31:0] wd);
    if (we && int'(a) < DEPTH) begin
      if (!model_mem.exists(int'(a))) written.push_back(int'(a));
      model_mem[int'(a)] = wd;
    end
  endfunction

  // Presents a request, waits for acceptance, then returns the cycle index at which rsp_valid appears.
  task automatic issue2(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                        output int lat, output bit ok);
    int guard = 0;
    req_valid2 = 1'b1; req_we2 = we; req_addr2 = addr; req_wdata2 = wd;
    lat = 0; ok = 1'b0;
    while (req_ready2 !== 1'b1 && guard < 40) begin step(); guard++; end
    if (req_ready2 !== 1'b1) begin req_valid2 = 1'b0; return; end
    step();
    req_valid2 = 1'b0;
    lat = 1;
    while (rsp_valid2 !== 1'b1 && lat < 40) begin step(); lat++; end
    ok = (rsp_valid2 === 1'b1);
  endtask

  task automatic complete2(input logic we, input logic [11:0] addr);
    $display("txn dut2 we=%0b addr=%0d rdata=%h err=%0b", we, addr, rsp_rdata2, rsp_err2);
    rsp_ready2 = 1'b1;
    step();
    rsp_ready2 = 1'b0;
    model_cnt2 = (model_cnt2 + 1) % 65536;
  endtask

  task automatic test_reset();
    rst2 = 1'b1; rst0 = 1'b1;
    req_valid2 = 0; req_we2 = 0; req_addr2 = 0; req_wdata2 = 0; rsp_ready2 = 0;
    req_valid0 = 0; req_we0 = 0; req_addr0 = 0; req_wdata0 = 0; rsp_ready0 = 0;
    step(); step();
    checks++;
    if (req_ready2 !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready2); end
    checks++;
    if ({rsp_valid2, rsp_err2, busy2} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got valid/err/busy=%b expected 000", {rsp_valid2, rsp_err2, busy2});
    end
    checks++;
    if (rsp_rdata2 !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rsp_rdata2); end
    checks++;
    if (txn_count2 !== 16'd0) begin errors++; $display("FAIL reset_txn_count: got %0d expected 0", txn_count2); end
    rst2 = 1'b0; rst0 = 1'b0;
    model_cnt2 = 0;
    step();
    checks++;
    if (req_ready2 !== 1'b1 || req_ready0 !== 1'b1) begin
      errors++; $display("FAIL post_reset_ready: got %b%b expected 11", req_ready2, req_ready0);
    end
  endtask

  task automatic test_store_load();
    int lat; bit ok;
    issue2(1'b1, 12'd5, 32'hDEADBEEF, lat, ok);
    checks++;
    if (!ok || lat != LAT2) begin errors++; $display("FAIL store_latency: got %0d ok=%0b expected %0d", lat, ok, LAT2); end
    checks++;
    if ({rsp_err2, rsp_rdata2} !== {1'b0, exp_rdata(1'b1, 12'd5)}) begin
      errors++; $display("FAIL store_rsp: got err=%b rdata=%h expected err=0 rdata=0", rsp_err2, rsp_rdata2);
    end
    model_apply(1'b1, 12'd5, 32'hDEADBEEF);
    complete2(1'b1, 12'd5);
    issue2(1'b0, 12'd5, 32'd0, lat, ok);
    checks++;
    if (!ok || lat != LAT2) begin errors++; $display("FAIL load_latency: got %0d ok=%0b expected %0d", lat, ok, LAT2); end
    checks++;
    if ({rsp_err2, rsp_rdata2} !== {1'b0, exp_rdata(1'b0, 12'd5)}) begin
      errors++; $display("FAIL load_rsp: got err=%b rdata=%h expected err=0 rdata=%h", rsp_err2, rsp_rdata2, exp_rdata(1'b0, 12'd5));
    end
    complete2(1'b0, 12'd5);
    checks++;
    if (txn_count2 !== 16'(model_cnt2) || rsp_valid2 !== 1'b0) begin
      errors++; $display("FAIL store_load_count: got count=%0d valid=%b expected count=%0d valid=0", txn_count2, rsp_valid2, model_cnt2);
    end
  endtask

  task automatic test_range();
    logic        we_t [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [11:0] a_t  [4] = '{12'd1024, 12'd4095, 12'd1023, 12'd1023};
    logic [31:0] wd_t [4] = '{32'd0, 32'd1, 32'h12345678, 32'd0};
    for (int i = 0; i < 4; i++) begin
      int lat; bit ok; logic [31:0] e_rd; logic e_err;
      e_rd  = exp_rdata(we_t[i], a_t[i]);
      e_err = (int'(a_t[i]) >= DEPTH);
      issue2(we_t[i], a_t[i], wd_t[i], lat, ok);
      checks++;
      if (!ok || {rsp_err2, rsp_rdata2} !== {e_err, e_rd}) begin
        errors++; $display("FAIL range_addr_%0d: got ok=%0b err=%b rdata=%h expected err=%b rdata=%h",
                           a_t[i], ok, rsp_err2, rsp_rdata2, e_err, e_rd);
      end
      model_apply(we_t[i], a_t[i], wd_t[i]);
      complete2(we_t[i], a_t[i]);
    end
    checks++;
    if (txn_count2 !== 16'(model_cnt2)) begin errors++; $display("FAIL range_count: got %0d expected %0d", txn_count2, model_cnt2); end
  endtask

  task automatic test_backpressure();
    int lat; bit ok; logic [31:0] e_rd; logic [15:0] e_cnt;
    e_rd  = exp_rdata(1'b0, 12'd5);
    e_cnt = 16'(model_cnt2);
    issue2(1'b0, 12'd5, 32'd0, lat, ok);
    // A competing store is held during the response; it must not be accepted.
    req_valid2 = 1'b1; req_we2 = 1'b1; req_addr2 = 12'd5; req_wdata2 = 32'h0BAD0BAD;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({rsp_valid2, rsp_err2, req_ready2, rsp_rdata2, txn_count2} !== {1'b1, 1'b0, 1'b0, e_rd, e_cnt}) begin
        errors++; $display("FAIL backpressure_c%0d: got valid=%b err=%b rdy=%b rdata=%h cnt=%0d expected 1 0 0 %h %0d",
                           i, rsp_valid2, rsp_err2, req_ready2, rsp_rdata2, txn_count2, e_rd, e_cnt);
      end
      step();
    end
    req_valid2 = 1'b0;
    complete2(1'b0, 12'd5);
    checks++;
    if (txn_count2 !== 16'(model_cnt2) || rsp_valid2 !== 1'b0) begin
      errors++; $display("FAIL backpressure_release: got cnt=%0d valid=%b expected %0d 0", txn_count2, rsp_valid2, model_cnt2);
    end
    issue2(1'b0, 12'd5, 32'd0, lat, ok);
    checks++;
    if (!ok || rsp_rdata2 !== exp_rdata(1'b0, 12'd5)) begin
      errors++; $display("FAIL ignored_store: got %h expected %h", rsp_rdata2, exp_rdata(1'b0, 12'd5));
    end
    complete2(1'b0, 12'd5);
  endtask

  // Abort a store to addr 7 with reset, `extra` cycles after the first WAIT cycle (2 lands on ACCESS).
  task automatic test_reset_mid(input int extra, input logic [31:0] wd);
    int lat; bit ok; int guard = 0; bit quiet = 1'b1;
    req_valid2 = 1'b1; req_we2 = 1'b1; req_addr2 = 12'd7; req_wdata2 = wd;
    while (req_ready2 !== 1'b1 && guard < 40) begin step(); guard++; end
    step();
    req_valid2 = 1'b0;
    repeat (extra) step();
    rst2 = 1'b1;
    step();
    rst2 = 1'b0;
    model_cnt2 = 0;
    checks++;
    if ({busy2, rsp_valid2, txn_count2} !== {1'b0, 1'b0, 16'd0}) begin
      errors++; $display("FAIL reset_mid_%0d: got busy=%b valid=%b cnt=%0d expected 0 0 0", extra, busy2, rsp_valid2, txn_count2);
    end
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid2 !== 1'b0) quiet = 1'b0;
      step();
    end
    checks++;
    if (!quiet) begin errors++; $display("FAIL reset_mid_noresp_%0d: got a response expected none", extra); end
    issue2(1'b0, 12'd7, 32'd0, lat, ok);
    checks++;
    if (!ok || rsp_rdata2 !== exp_rdata(1'b0, 12'd7)) begin
      errors++; $display("FAIL reset_mid_data_%0d: got %h expected %h", extra, rsp_rdata2, exp_rdata(1'b0, 12'd7));
    end
    complete2(1'b0, 12'd7);
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      int kind; int lat; bit ok; logic we; logic [11:0] a; logic [31:0] wd; logic [31:0] e_rd; logic e_err;
      kind = $urandom_range(0, 9);
      wd   = $urandom;
      if (kind < 2) begin
        a = 12'($urandom_range(1024, 4095)); we = 1'($urandom_range(0, 1));
      end else if (kind < 6 || written.size() == 0) begin
        a = 12'($urandom_range(0, 1023)); we = 1'b1;
      end else begin
        a = 12'(written[$urandom_range(0, written.size() - 1)]); we = 1'b0;
      end
      e_rd  = exp_rdata(we, a);
      e_err = (int'(a) >= DEPTH);
      rsp_ready2 = 1'($urandom_range(0, 1));
      issue2(we, a, wd, lat, ok);
      checks++;
      if (!ok || lat != LAT2 || {rsp_err2, rsp_rdata2} !== {e_err, e_rd}) begin
        errors++; $display("FAIL random_%0d: got lat=%0d err=%b rdata=%h expected lat=%0d err=%b rdata=%h",
                           i, lat, rsp_err2, rsp_rdata2, LAT2, e_err, e_rd);
      end
      model_apply(we, a, wd);
      if (rsp_ready2 !== 1'b1) repeat ($urandom_range(0, 3)) step();
      complete2(we, a);
      checks++;
      if (txn_count2 !== 16'(model_cnt2)) begin errors++; $display("FAIL random_count_%0d: got %0d expected %0d", i, txn_count2, model_cnt2); end
    end
  endtask

  task automatic test_back_to_back();
    int acc_t [$]; int rise_t [$]; int cyc = 0; logic acc; logic pv;
    rsp_ready0 = 1'b1; req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 12'd100; req_wdata0 = $urandom;
    while (rise_t.size() < 3 && cyc < 40) begin
      acc = req_valid0 && req_ready0;
      pv  = rsp_valid0;
      step(); cyc++;
      if (acc) begin
        acc_t.push_back(cyc);
        $display("txn dut0 store addr=%0d accepted at cycle %0d", req_addr0, cyc);
        if (acc_t.size() == 3) req_valid0 = 1'b0;
        else begin req_addr0 = 12'(100 + acc_t.size()); req_wdata0 = $urandom; end
      end
      if (rsp_valid0 === 1'b1 && pv !== 1'b1) rise_t.push_back(cyc);
    end
    step();
    rsp_ready0 = 1'b0; req_valid0 = 1'b0;
    checks++;
    if (acc_t.size() != 3 || rise_t.size() != 3) begin
      errors++; $display("FAIL b2b_events: got %0d accepts %0d responses expected 3 3", acc_t.size(), rise_t.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (acc_t[i] - acc_t[i-1] != PER0) begin
          errors++; $display("FAIL b2b_period_%0d: got %0d expected %0d", i, acc_t[i] - acc_t[i-1], PER0);
        end
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rise_t[i] - acc_t[i] + 1 != LAT0) begin
          errors++; $display("FAIL b2b_latency_%0d: got %0d expected %0d", i, rise_t[i] - acc_t[i] + 1, LAT0);
        end
      end
    end
    checks++;
    if (txn_count0 !== 16'd3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", txn_count0); end
  endtask

  task automatic test_wrap();
    int lat; bit ok;
    force dut2.txn_count_reg = 16'hFFFF;
    #1;
    release dut2.txn_count_reg;
    model_cnt2 = 65535;
    checks++;
    if (txn_count2 !== 16'(model_cnt2)) begin errors++; $display("FAIL wrap_preload: got %h expected %h", txn_count2, 16'(model_cnt2)); end
    issue2(1'b0, 12'd1023, 32'd0, lat, ok);
    checks++;
    if (!ok || rsp_rdata2 !== exp_rdata(1'b0, 12'd1023)) begin
      errors++; $display("FAIL wrap_data: got %h expected %h", rsp_rdata2, exp_rdata(1'b0, 12'd1023));
    end
    complete2(1'b0, 12'd1023);
    checks++;
    if (txn_count2 !== 16'(model_cnt2)) begin errors++; $display("FAIL wrap_count: got %h expected %h", txn_count2, 16'(model_cnt2)); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_store_load();
    test_range();
    test_backpressure();
    model_apply(1'b1, 12'd7, 32'h55);
    begin
      int lat; bit ok;
      issue2(1'b1, 12'd7, 32'h55, lat, ok);
      complete2(1'b1, 12'd7);
    end
    test_reset_mid(0, 32'hAA);
    test_reset_mid(2, 32'hCC);
    test_random(40);
    test_back_to_back();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
